// File: rtl/heating_dut.sv
// Air-conditioning mode controller: IDLE/HEAT/COOL/FAULT with compressor
// minimum-run and idle hold-off timers, plus front-panel LED decode.
module heating_dut #(
  parameter int MIN_RUN   = 4,
  parameter int MIN_IDLE  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic clock,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic status,
  output logic LG,
  output logic LR
);
  localparam int RW = $clog2(MIN_RUN + 1);
  localparam int IW = $clog2(MIN_IDLE + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(MIN_RUN);
  localparam logic [RW-1:0] RUN_LAST   = RW'(MIN_RUN - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(MIN_IDLE);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   run_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink;
  logic            run_done, idle_done;

  assign run_done  = (run_cnt >= RUN_LAST);
  assign idle_done = (idle_cnt >= IDLE_MAX);

  // Simultaneous requests win over everything, including the timers.
  always_comb begin
    state_nxt = state;
    if (A && B) state_nxt = FAULT;
    else begin
      case (state)
        IDLE: begin
          if (A && !status && idle_done)     state_nxt = HEAT;
          else if (B && status && idle_done) state_nxt = COOL;
        end
        HEAT:  if ((!A || status) && run_done) state_nxt = IDLE;
        COOL:  if ((!B || !status) && run_done) state_nxt = IDLE;
        FAULT: if (!A && !B) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= IDLE;
      run_cnt   <= '0;
      idle_cnt  <= IDLE_MAX;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt == HEAT || state_nxt == COOL) begin
        if (state != state_nxt)    run_cnt <= '0;
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
      end

      if (state_nxt == IDLE) begin
        if (state != IDLE)            idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      end

      // Blink phase restarts lit on every fresh fault entry.
      if (state_nxt == FAULT) begin
        if (state != FAULT) begin
          blink_cnt <= '0;
          blink     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end
    end
  end

  assign LG = (state == COOL) || ((state == FAULT) && blink);
  assign LR = (state == HEAT) || ((state == FAULT) && blink);
endmodule

// File: tb/tb_heating_dut.sv
// Directed vector bench for heating_dut: table of per-edge inputs and
// expected LEDs, plus hand sequences for fault blinking and reset mid-HEAT.
module tb_heating_dut;
  logic clock, rst, A, B, status;
  logic LG, LR;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic r, a, b, s;
    logic lg, lr;
  } vec_t;
  vec_t vecs[$];

  heating_dut #(.MIN_RUN(4), .MIN_IDLE(4), .BLINK_DIV(8)) dut (
    .clock(clock), .rst(rst), .A(A), .B(B), .status(status), .LG(LG), .LR(LR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic addn(input int n, input logic r, a, b, s, lg, lr);
    for (int i = 0; i < n; i++) vecs.push_back('{r, a, b, s, lg, lr});
  endtask

  task automatic step(input logic r, a, b, s, elg, elr, input string nm, input int idx);
    rst = r; A = a; B = b; status = s;
    @(posedge clock);
    #1;
    checks++;
    if (LG !== elg || LR !== elr) begin
      errors++;
      $display("FAIL %s[%0d]: LG=%b LR=%b, expected LG=%b LR=%b", nm, idx, LG, LR, elg, elr);
    end
  endtask

  initial begin
    rst = 1'b0; A = 1'b0; B = 1'b0; status = 1'b0;

    //   n  rst A  B  st  LG LR
    addn(2,  0, 1, 0, 0,  0, 0);  // reset overrides heat request
    addn(2,  1, 1, 0, 0,  0, 1);  // hold-off expired after reset: HEAT next edge
    addn(2,  1, 0, 0, 0,  0, 1);  // min run not yet reached
    addn(1,  1, 0, 0, 0,  0, 0);  // run_cnt==3: exit
    addn(4,  1, 0, 1, 1,  0, 0);  // idle hold-off
    addn(10, 1, 0, 1, 1,  1, 0);  // COOL for 10 cycles
    addn(1,  1, 0, 0, 1,  0, 0);  // min run long satisfied: exit at once
    addn(4,  1, 0, 1, 1,  0, 0);  // immediate re-request held off
    addn(1,  1, 0, 1, 1,  1, 0);  // COOL again
    addn(3,  1, 0, 0, 1,  1, 0);  // short COOL must finish min run
    addn(1,  1, 0, 0, 1,  0, 0);
    addn(8,  1, 0, 1, 0,  0, 0);  // cool request in heating season ignored
    addn(2,  1, 1, 0, 1,  0, 0);  // heat request in cooling season ignored
    addn(2,  1, 1, 0, 0,  0, 1);  // HEAT
    addn(2,  1, 1, 0, 1,  0, 1);  // season flip still waits for min run
    addn(1,  1, 1, 0, 1,  0, 0);
    addn(4,  1, 1, 0, 0,  0, 0);  // hold-off before heat re-entry
    addn(1,  1, 1, 0, 0,  0, 1);

    foreach (vecs[i])
      step(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lg, vecs[i].lr, "vec", i);

    // FAULT from HEAT: lit for 8 cycles, dark for 8, lit again; a single
    // request keeps FAULT and the blink phase runs on undisturbed.
    for (int i = 0; i < 18; i++) begin
      logic e;
      e = ((i / 8) % 2) == 0;
      step(1, 1, 1, 0, e, e, "blink", i);
    end
    for (int i = 18; i < 20; i++) begin
      logic e;
      e = ((i / 8) % 2) == 0;
      step(1, 1, 0, 0, e, e, "fault_hold", i);
    end
    step(1, 0, 0, 0, 0, 0, "fault_exit", 0);

    // Back to HEAT, then reset pulse mid-run.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, "holdoff2", i);
    step(1, 1, 0, 0, 0, 1, "heat2", 0);
    step(1, 1, 0, 0, 0, 1, "heat2", 1);
    step(0, 1, 0, 0, 0, 0, "rst_pulse", 0);
    step(1, 1, 0, 0, 0, 1, "rst_release", 0);  // idle_cnt back at MIN_IDLE
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, "run_after_rst", i);
    step(1, 0, 0, 0, 0, 0, "run_after_rst_exit", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
